// File: rtl/divider_ctrl.sv
// divider_ctrl: programmable clock divider with run/stop control and a
// ratio reload that only takes effect on a period boundary (or at once in IDLE).
module divider_ctrl #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned DEFAULT_RATIO = 4
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_START,
  input  logic             i_STOP,
  input  logic             i_LOAD,
  input  logic [WIDTH-1:0] i_RATIO,
  output logic             o_CLK,
  output logic             o_TICK,
  output logic             o_RUN,
  output logic             o_PEND,
  output logic             o_LOAD_ACK,
  output logic             o_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] RATIO_RST = WIDTH'(DEFAULT_RATIO);
  localparam logic [WIDTH-1:0] RATIO_MIN = WIDTH'(2);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_ratio;
  logic [WIDTH-1:0] r_pend_ratio;
  logic             r_pend;

  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_ratio_nxt;
  logic [WIDTH-1:0] w_pend_ratio_nxt;
  logic [WIDTH-1:0] w_high_nxt;
  logic             w_pend_nxt;
  logic             w_boundary;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_apply;
  logic             w_run_nxt;
  logic             w_clk_nxt;
  logic             w_tick_nxt;

  // Last cycle of a period while the divider is active.
  assign w_boundary = (r_state != ST_IDLE) && (r_cnt == (r_ratio - WIDTH'(1)));

  // Ratio requests below 2 are rejected and only flagged.
  assign w_load_ok  = i_LOAD && (i_RATIO >= RATIO_MIN);
  assign w_load_bad = i_LOAD && (i_RATIO <  RATIO_MIN);

  // A pending ratio is promoted immediately in IDLE, otherwise on a boundary.
  assign w_apply = r_pend && ((r_state == ST_IDLE) || w_boundary);

  // State register.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter and next-output decode; STOP always beats START.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = '0;
    w_ratio_nxt      = w_apply ? r_pend_ratio : r_ratio;
    w_pend_ratio_nxt = w_load_ok ? i_RATIO : r_pend_ratio;
    w_pend_nxt       = w_load_ok || (r_pend && !w_apply);

    case (r_state)
      ST_IDLE: begin
        if (i_START && !i_STOP) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_STOP) begin
          w_state_nxt = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (i_START && !i_STOP) begin
          w_state_nxt = ST_RUN;
        end else if (w_boundary) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Counter runs freely while active; a fresh start always begins at 0.
    if ((r_state != ST_IDLE) && !w_boundary) begin
      w_cnt_nxt = r_cnt + WIDTH'(1);
    end
    if (w_state_nxt == ST_IDLE) begin
      w_cnt_nxt = '0;
    end

    // High phase length of the period being entered: ceil(R/2).
    w_high_nxt = w_ratio_nxt - (w_ratio_nxt >> 1);
    w_run_nxt  = (w_state_nxt != ST_IDLE);
    w_clk_nxt  = w_run_nxt && (w_cnt_nxt < w_high_nxt);
    w_tick_nxt = w_run_nxt && (w_cnt_nxt == '0);
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_cnt        <= '0;
      r_ratio      <= RATIO_RST;
      r_pend_ratio <= RATIO_RST;
      r_pend       <= 1'b0;
      o_CLK        <= 1'b0;
      o_TICK       <= 1'b0;
      o_RUN        <= 1'b0;
      o_PEND       <= 1'b0;
      o_LOAD_ACK   <= 1'b0;
      o_ERR        <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_ratio      <= w_ratio_nxt;
      r_pend_ratio <= w_pend_ratio_nxt;
      r_pend       <= w_pend_nxt;
      o_CLK        <= w_clk_nxt;
      o_TICK       <= w_tick_nxt;
      o_RUN        <= w_run_nxt;
      o_PEND       <= w_pend_nxt;
      o_LOAD_ACK   <= w_apply;
      o_ERR        <= w_load_bad;
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed bench for divider_ctrl; expected output vectors are queued when a
// step is driven and checked once the DUT has clocked it in.
module tb_divider_ctrl;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic         load;
  logic [W-1:0] ratio;
  logic         o_clk;
  logic         o_tick;
  logic         o_run;
  logic         o_pend;
  logic         o_ack;
  logic         o_err;

  logic [5:0]   sb_q[$];
  int           n_vec;
  int           n_err;

  divider_ctrl #(.WIDTH(W), .DEFAULT_RATIO(4)) dut (
    .i_CLK      (clk),
    .i_RST      (rst),
    .i_START    (start),
    .i_STOP     (stop),
    .i_LOAD     (load),
    .i_RATIO    (ratio),
    .o_CLK      (o_clk),
    .o_TICK     (o_tick),
    .o_RUN      (o_run),
    .o_PEND     (o_pend),
    .o_LOAD_ACK (o_ack),
    .o_ERR      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: {o_CLK, o_TICK, o_RUN, o_PEND, o_LOAD_ACK, o_ERR}
  function automatic logic [5:0] outs();
    return {o_clk, o_tick, o_run, o_pend, o_ack, o_err};
  endfunction

  task automatic check_pop(input string tag);
    logic [5:0] got;
    logic [5:0] exp;
    got = outs();
    exp = sb_q.pop_front();
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b (clk,tick,run,pend,ack,err)", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, check after the edge.
  task automatic step(input logic st, input logic sp, input logic ld,
                      input logic [W-1:0] ra, input logic [5:0] exp, input string tag);
    start = st;
    stop  = sp;
    load  = ld;
    ratio = ra;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    load  = 1'b0;
    ratio = '0;
    @(posedge clk);
    #1;
    sb_q.push_back(6'b000000);
    check_pop("reset");
    rst = 1'b0;

    // Default ratio 4: 1,1,0,0 with tick on the first RUN cycle
    step(1, 0, 0, 0, 6'b111000, "r4_c0");
    step(1, 0, 0, 0, 6'b101000, "r4_c1");
    step(1, 0, 0, 0, 6'b001000, "r4_c2");
    step(1, 0, 0, 0, 6'b001000, "r4_c3");
    step(1, 0, 0, 0, 6'b111000, "r4_c0b");
    step(1, 0, 0, 0, 6'b101000, "r4_c1b");
    step(1, 0, 0, 0, 6'b001000, "r4_c2b");
    step(1, 0, 0, 0, 6'b001000, "r4_c3b");
    step(1, 0, 0, 0, 6'b111000, "r4_c0c");
    step(0, 0, 0, 0, 6'b101000, "r4_c1c");

    // Load 5 at cnt=1: pending until the boundary, then 1,1,1,0,0
    step(0, 0, 1, 5, 6'b001100, "ld5_c2");
    step(0, 0, 0, 0, 6'b001100, "ld5_c3");
    step(0, 0, 0, 0, 6'b111010, "ld5_ack");
    step(0, 0, 0, 0, 6'b101000, "r5_c1");
    step(0, 0, 0, 0, 6'b101000, "r5_c2");
    step(0, 0, 0, 0, 6'b001000, "r5_c3");
    step(0, 0, 0, 0, 6'b001000, "r5_c4");
    step(0, 0, 0, 0, 6'b111000, "r5_c0");

    // Switch to ratio 6
    step(0, 0, 1, 6, 6'b101100, "ld6_c1");
    step(0, 0, 0, 0, 6'b101100, "ld6_c2");
    step(0, 0, 0, 0, 6'b001100, "ld6_c3");
    step(0, 0, 0, 0, 6'b001100, "ld6_c4");
    step(0, 0, 0, 0, 6'b111010, "ld6_ack");

    // Stop at cnt=0 with R=6: full period completes, then IDLE
    step(0, 1, 0, 0, 6'b101000, "stp_c1");
    step(0, 0, 0, 0, 6'b101000, "stp_c2");
    step(0, 0, 0, 0, 6'b001000, "stp_c3");
    step(0, 0, 0, 0, 6'b001000, "stp_c4");
    step(0, 0, 0, 0, 6'b001000, "stp_c5");
    step(0, 0, 0, 0, 6'b000000, "stp_idle");
    step(0, 0, 0, 0, 6'b000000, "stp_idle2");

    // START during STOPPING cancels the stop, o_RUN never drops
    step(1, 0, 0, 0, 6'b111000, "cx_c0");
    step(0, 1, 0, 0, 6'b101000, "cx_c1");
    step(1, 0, 0, 0, 6'b101000, "cx_c2");
    step(0, 0, 0, 0, 6'b001000, "cx_c3");
    step(0, 0, 0, 0, 6'b001000, "cx_c4");
    step(0, 0, 0, 0, 6'b001000, "cx_c5");
    step(0, 0, 0, 0, 6'b111000, "cx_c0b");

    // START and STOP together: STOP wins in STOPPING and IDLE
    step(1, 1, 0, 0, 6'b101000, "both_c1");
    step(1, 1, 0, 0, 6'b101000, "both_c2");
    step(1, 1, 0, 0, 6'b001000, "both_c3");
    step(1, 1, 0, 0, 6'b001000, "both_c4");
    step(1, 1, 0, 0, 6'b001000, "both_c5");
    step(1, 1, 0, 0, 6'b000000, "both_idle");
    step(1, 1, 0, 0, 6'b000000, "both_idle2");

    // Illegal ratios 1 and 0 only raise o_ERR
    step(0, 0, 1, 1, 6'b000001, "err_r1");
    step(0, 0, 1, 0, 6'b000001, "err_r0");
    step(0, 0, 0, 0, 6'b000000, "err_clr");
    step(1, 0, 0, 0, 6'b111000, "err_c0");
    step(0, 0, 0, 0, 6'b101000, "err_c1");
    step(0, 0, 0, 0, 6'b101000, "err_c2");
    step(0, 1, 0, 0, 6'b001000, "err_c3");
    step(0, 0, 0, 0, 6'b001000, "err_c4");
    step(0, 0, 0, 0, 6'b001000, "err_c5");
    step(0, 0, 0, 0, 6'b000000, "err_idle");

    // Back-to-back loads 7 then 3 merge into a single ack
    step(1, 0, 0, 0, 6'b111000, "mg_c0");
    step(0, 0, 1, 7, 6'b101100, "mg_ld7");
    step(0, 0, 1, 3, 6'b101100, "mg_ld3");
    step(0, 0, 0, 0, 6'b001100, "mg_c3");
    step(0, 0, 0, 0, 6'b001100, "mg_c4");
    step(0, 0, 0, 0, 6'b001100, "mg_c5");
    step(0, 0, 0, 0, 6'b111010, "mg_ack");
    step(0, 0, 0, 0, 6'b101000, "r3_c1");
    step(0, 0, 0, 0, 6'b001000, "r3_c2");
    step(0, 0, 0, 0, 6'b111000, "r3_c0");

    // Load on a boundary while pending: old value applied, new stays pending
    step(0, 0, 1, 4, 6'b101100, "bd_ld4");
    step(0, 0, 0, 0, 6'b001100, "bd_c2");
    step(0, 0, 1, 5, 6'b111110, "bd_ld5");
    step(0, 0, 0, 0, 6'b101100, "bd_r4c1");
    step(0, 0, 0, 0, 6'b001100, "bd_r4c2");
    step(0, 0, 0, 0, 6'b001100, "bd_r4c3");
    step(0, 0, 0, 0, 6'b111010, "bd_ack5");

    // Back to IDLE with R=5
    step(0, 1, 0, 0, 6'b101000, "i5_c1");
    step(0, 0, 0, 0, 6'b101000, "i5_c2");
    step(0, 0, 0, 0, 6'b001000, "i5_c3");
    step(0, 0, 0, 0, 6'b001000, "i5_c4");
    step(0, 0, 0, 0, 6'b000000, "i5_idle");

    // IDLE apply coinciding with START uses the new ratio 2
    step(0, 0, 1, 2, 6'b000100, "ia_pend");
    step(1, 0, 0, 0, 6'b111010, "ia_start");
    step(0, 0, 0, 0, 6'b001000, "r2_c1");
    step(0, 0, 0, 0, 6'b111000, "r2_c0");
    step(0, 1, 0, 0, 6'b001000, "r2_stp");
    step(0, 0, 0, 0, 6'b000000, "r2_idle");

    // Plain IDLE apply: ack the cycle after acceptance
    step(0, 0, 1, 4, 6'b000100, "ib_pend");
    step(0, 0, 0, 0, 6'b000010, "ib_ack");
    step(0, 0, 0, 0, 6'b000000, "ib_idle");

    // Load 6 then reset asynchronously during the high phase
    step(1, 0, 0, 0, 6'b111000, "rs_c0");
    step(0, 0, 1, 6, 6'b101100, "rs_pend");
    load  = 1'b0;
    ratio = '0;
    rst   = 1'b1;
    #2;
    sb_q.push_back(6'b000000);
    check_pop("rs_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 0, 0, 6'b000000, "rs_noack");
    step(0, 0, 0, 0, 6'b000000, "rs_idle");
    step(1, 0, 0, 0, 6'b111000, "rs_c0b");
    step(1, 0, 0, 0, 6'b101000, "rs_c1");
    step(1, 0, 0, 0, 6'b001000, "rs_c2");
    step(1, 0, 0, 0, 6'b001000, "rs_c3");
    step(0, 0, 0, 0, 6'b111000, "rs_c0c");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/divider_ctrl.md
DIVIDER_CTRL -- requirements
Module: divider_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: width of the ratio field and the period counter.
REQ-002 Parameter DEFAULT_RATIO, default 4: active ratio after reset; SHALL be >= 2.
REQ-003 i_CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_RST  input  1  asynchronous, active-high reset.
REQ-005 i_START  input  1  level-sampled run request.
REQ-006 i_STOP  input  1  level-sampled stop request.
REQ-007 i_LOAD  input  1  one-cycle ratio-change request.
REQ-008 i_RATIO  input  WIDTH  new ratio, sampled only when i_LOAD=1.
REQ-009 o_CLK  output  1  registered divided clock.
REQ-010 o_TICK  output  1  one-cycle pulse on the cycle o_CLK goes 0->1.
REQ-011 o_RUN  output  1  high in states RUN and STOPPING.
REQ-012 o_PEND  output  1  high while an accepted ratio change is not yet applied.
REQ-013 o_LOAD_ACK  output  1  one-cycle pulse on the cycle a pending ratio becomes active.
REQ-014 o_ERR  output  1  one-cycle pulse when i_LOAD carries i_RATIO < 2.

Function
REQ-015 FSM states: IDLE, RUN, STOPPING; all outputs registered.
REQ-016 Registers: active ratio R, pending ratio P, period counter cnt (0..R-1), high length H = R - (R>>1), i.e. ceil(R/2).
REQ-017 IDLE: cnt=0, o_CLK=0, o_TICK=0; i_START=1 and i_STOP=0 -> RUN on the next edge.
REQ-018 The first RUN cycle SHALL show cnt=0, o_CLK=1, o_TICK=1 (latency: 1 cycle from i_START sampled).
REQ-019 RUN/STOPPING: cnt increments each cycle; at cnt=R-1 it wraps to 0 (period boundary).
REQ-020 o_CLK SHALL be 1 for cnt < H and 0 otherwise: H cycles high, R>>1 cycles low, period exactly R cycles.
REQ-021 o_TICK SHALL be 1 exactly on cycles where cnt=0 in RUN/STOPPING.
REQ-022 i_STOP=1 in RUN -> STOPPING; the current period completes unmodified.
REQ-023 STOPPING at boundary (cnt=R-1) -> IDLE; no truncated high or low phase is ever emitted.
REQ-024 i_START=1 and i_STOP=0 in STOPPING -> RUN, stop cancelled, counting continues without disturbance.
REQ-025 i_START and i_STOP both 1: STOP wins in every state.
REQ-026 i_LOAD=1 with i_RATIO >= 2: P <= i_RATIO, o_PEND <= 1 on the next edge.
REQ-027 i_LOAD=1 with i_RATIO < 2: o_ERR pulses the next cycle; P, R and o_PEND unchanged.
REQ-028 Apply point in RUN/STOPPING: at the period boundary, R <= P, o_PEND <= 0, o_LOAD_ACK pulses; the new period starts with the new R.
REQ-029 Apply point in IDLE: the cycle after acceptance, R <= P, o_PEND <= 0, o_LOAD_ACK pulses.
REQ-030 i_LOAD while o_PEND=1: P is overwritten; one o_LOAD_ACK covers all merged requests.
REQ-031 i_LOAD coinciding with a boundary: the current pending value is applied and the new value becomes pending, o_PEND stays 1.
REQ-032 A START taken in the same cycle as an IDLE apply SHALL use the new R.
REQ-033 Counter arithmetic is unsigned WIDTH bits; ratios up to 2^WIDTH-1 are legal.

Reset
REQ-034 i_RST=1 asynchronously forces IDLE, cnt=0, R=DEFAULT_RATIO, P=DEFAULT_RATIO, and all outputs 0.
REQ-035 Reset mid-period drops the pending change without an ack; the first edge after release behaves as IDLE.

Verification
REQ-036 Reset, START held 1 with default R=4 -> o_CLK 1,1,0,0 repeating, o_TICK every 4th cycle starting on the cycle after START.
REQ-037 LOAD ratio 5 at cnt=1 with R=4 -> o_PEND=1, o_LOAD_ACK on the next cnt=0, then pattern 1,1,1,0,0.
REQ-038 STOP at cnt=0 with R=6 -> o_CLK completes 1,1,1,0,0,0, then IDLE with o_RUN=0, o_CLK=0; a START during STOPPING keeps o_RUN=1 continuously.
REQ-039 LOAD ratio 1, then LOAD ratio 0 -> o_ERR pulses twice; R unchanged, o_PEND=0.
REQ-040 Back-to-back LOAD 7 then LOAD 3 within one period -> a single o_LOAD_ACK, and the next period is 3 cycles (1,1,0).
REQ-041 Assert i_RST mid-high phase with o_PEND=1 -> all outputs 0 immediately, without waiting for a clock edge; no ack after release; R=DEFAULT_RATIO.
